// File: rtl/spi_master_tx.sv
// Pixel-to-SPI serialiser: expands one packed pixel per handshake into a 32-bit
// word and shifts it out MSB-first. It also drives spi_reset, which keeps the
// receiver's word alignment in step with this block.
module spi_master_tx #(
  parameter int unsigned BITS_PER_PIXEL = 16,
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned SYNC_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      spi_clk,
  output logic                      spi_mosi,
  output logic                      spi_reset,
  output logic                      busy
);

  localparam int unsigned BITS_PER_RGB = BITS_PER_PIXEL / 4;
  localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SYNC_W       = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_W-1:0]  sync_cnt_q, sync_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               high_q, high_d;
  logic [31:0]        shift_q, shift_d;
  logic               spi_clk_q, spi_clk_d;
  logic               mosi_q, mosi_d;
  logic               spi_reset_q, spi_reset_d;
  logic [31:0]        word;

  // Expand each channel into the top bits of its byte, zero-filling the rest.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      word[8*k+7 -: BITS_PER_RGB] = pixel_data[k*BITS_PER_RGB +: BITS_PER_RGB];
    end
  end

  // State and datapath registers; reset drops the link to SYNC and discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      high_q      <= 1'b0;
      shift_q     <= '0;
      spi_clk_q   <= 1'b0;
      mosi_q      <= 1'b0;
      spi_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      high_q      <= high_d;
      shift_q     <= shift_d;
      spi_clk_q   <= spi_clk_d;
      mosi_q      <= mosi_d;
      spi_reset_q <= spi_reset_d;
    end
  end

  // Next-state logic: sync countdown, word capture, and the low/high phase bit sequencer.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    high_d      = high_q;
    shift_d     = shift_q;
    spi_clk_d   = spi_clk_q;
    mosi_d      = mosi_q;
    spi_reset_d = spi_reset_q;
    case (state_q)
      ST_SYNC: begin
        spi_reset_d = 1'b1;
        if (sync_cnt_q == SYNC_LAST) begin
          sync_cnt_d  = '0;
          spi_reset_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          sync_cnt_d = sync_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        spi_clk_d = 1'b0;
        mosi_d    = 1'b0;
        if (pixel_valid) begin
          // Bit 31 is presented on the same edge that starts its low phase.
          shift_d   = word;
          mosi_d    = word[31];
          bit_cnt_d = 5'd31;
          div_cnt_d = '0;
          high_d    = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!high_q) begin
            high_d    = 1'b1;
            spi_clk_d = 1'b1;
          end else begin
            high_d    = 1'b0;
            spi_clk_d = 1'b0;
            if (bit_cnt_q == 5'd0) begin
              mosi_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q - 1'b1;
              shift_d   = {shift_q[30:0], 1'b0};
              mosi_d    = shift_q[30];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign pixel_ready = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_SHIFT);
  assign spi_clk     = spi_clk_q;
  assign spi_mosi    = mosi_q;
  assign spi_reset   = spi_reset_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a 16-bpp and a 32-bpp instance share clock and reset.
// Serial output is reconstructed by receiver models and compared with words
// expanded from the pixel by plain arithmetic.
module tb_spi_master_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] p16_data = '0;
  logic        p16_valid = 1'b0;
  logic        r16, c16, m16, s16r, b16;
  logic [31:0] p32_data = '0;
  logic        p32_valid = 1'b0;
  logic        r32, c32, m32, s32r, b32;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_master_tx #(.BITS_PER_PIXEL(16), .CLK_DIV(2), .SYNC_CYCLES(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .pixel_data(p16_data), .pixel_valid(p16_valid),
    .pixel_ready(r16), .spi_clk(c16), .spi_mosi(m16), .spi_reset(s16r), .busy(b16)
  );

  spi_master_tx #(.BITS_PER_PIXEL(32), .CLK_DIV(2), .SYNC_CYCLES(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .pixel_data(p32_data), .pixel_valid(p32_valid),
    .pixel_ready(r32), .spi_clk(c32), .spi_mosi(m32), .spi_reset(s32r), .busy(b32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference word: channel k lands in byte k, left-justified.
  function automatic logic [31:0] expand(input logic [31:0] pix, input int unsigned bpp);
    int unsigned bpr;
    logic [31:0] w, ch, mask;
    bpr  = bpp / 4;
    mask = (32'd1 << bpr) - 32'd1;
    w    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      ch = (pix >> (k * bpr)) & mask;
      w  = w | (ch << (8 * k + 8 - bpr));
    end
    return w;
  endfunction

  // Receiver model for the 16-bpp link: collects whole words; spi_reset drops partial bits.
  logic [31:0] acc16 = '0;
  int unsigned cnt16 = 0;
  int unsigned rises16 = 0;
  logic [31:0] q16[$];
  always @(posedge c16 or posedge s16r) begin
    if (s16r) cnt16 = 0;
    else begin
      acc16 = {acc16[30:0], m16};
      cnt16++;
      rises16++;
      if (cnt16 == 32) begin
        q16.push_back(acc16);
        cnt16 = 0;
      end
    end
  end

  // Receiver model for the 32-bpp link: word N is published on the first rise of word N+1.
  logic [31:0] acc32 = '0, hold32 = '0;
  int unsigned cnt32 = 0;
  bit          pend32 = 0;
  logic [31:0] pub32[$];
  always @(posedge c32 or posedge s32r) begin
    if (s32r) begin
      cnt32  = 0;
      pend32 = 0;
    end else begin
      if (pend32) begin
        pub32.push_back(hold32);
        pend32 = 0;
      end
      acc32 = {acc32[30:0], m32};
      cnt32++;
      if (cnt32 == 32) begin
        hold32 = acc32;
        pend32 = 1;
        cnt32  = 0;
      end
    end
  end

  // mosi must hold its value across every clk cycle of an spi_clk high phase.
  logic hold16_v = 1'b0, hold16_ok = 1'b0;
  always @(negedge clk) begin
    if (reset_n && c16) begin
      if (hold16_ok) check("mosi_stable_high", m16, hold16_v);
      else begin
        hold16_v  = m16;
        hold16_ok = 1'b1;
      end
    end else hold16_ok = 1'b0;
  end

  task automatic send(input bit is32, input logic [31:0] pix, input logic [31:0] junk, input string tag);
    int unsigned w, n;
    w = 0;
    @(negedge clk);
    while (!(is32 ? r32 : r16) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_wait"}, 32'(w < 2000), 32'd1);
    if (is32) begin p32_data = pix; p32_valid = 1'b1; end
    else begin p16_data = pix[15:0]; p16_valid = 1'b1; end
    @(posedge clk);
    #1;
    // New data after the accept edge must not leak into the word in flight.
    if (is32) begin p32_valid = 1'b0; p32_data = junk; end
    else begin p16_valid = 1'b0; p16_data = junk[15:0]; end
    n = 0;
    while ((is32 ? b32 : b16) && n < 1000) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, n, 32'd128);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pix, exp, r1, r2;
    logic [31:0] pixs[3];
    int unsigned acc_t[3];
    int unsigned n_acc, guard, rises0;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    check("rst_spi_clk", c16, 0);
    check("rst_mosi", m16, 0);
    check("rst_ready", r16, 0);
    check("rst_busy", b16, 0);
    check("rst_spi_reset", s16r, 1);
    check("rst_spi_reset32", s32r, 1);

    // SYNC: spi_reset high for 4 edges after release, ready on the 4th.
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check("sync_spi_reset", s16r, (i < 4) ? 1 : 0);
      check("sync_ready", r16, (i == 4) ? 1 : 0);
      check("sync_spi_clk", c16, 0);
      check("sync_mosi", m16, 0);
    end
    check("sync_ready32", r32, 1);

    // Directed 16-bpp pixel.
    send(0, 32'h0000_F00F, $urandom, "f00f");
    check("f00f_words", q16.size(), 1);
    if (q16.size() != 0) check("f00f_word", q16.pop_front(), 32'hF000_00F0);

    // Random 16-bpp pixels, data scrambled right after accept.
    for (int i = 0; i < 4; i++) begin
      pix = $urandom & 32'hFFFF;
      send(0, pix, $urandom, "rnd16");
      check("rnd16_words", q16.size(), 1);
      if (q16.size() != 0) check("rnd16_word", q16.pop_front(), expand(pix, 16));
    end

    // 32-bpp pass-through, flushed out of the receiver by a dummy word.
    send(1, 32'hDEAD_BEEF, $urandom, "beef");
    check("beef_unflushed", pub32.size(), 0);
    send(1, $urandom, $urandom, "dummy");
    check("beef_pub_count", pub32.size(), 1);
    if (pub32.size() != 0) check("beef_word", pub32.pop_front(), 32'hDEAD_BEEF);
    void'(pub32.pop_front());
    r1 = $urandom;
    r2 = $urandom;
    send(1, r1, $urandom, "rnd32a");
    send(1, r2, $urandom, "rnd32b");
    pub32.delete();
    send(1, $urandom, $urandom, "rnd32c");
    check("rnd32_pub_count", pub32.size(), 1);
    if (pub32.size() != 0) check("rnd32_word", pub32.pop_front(), expand(r2, 32));

    // Back-to-back with pixel_valid held high.
    for (int i = 0; i < 3; i++) pixs[i] = $urandom & 32'hFFFF;
    rises0 = rises16;
    n_acc = 0;
    guard = 0;
    p16_data = pixs[0][15:0];
    p16_valid = 1'b1;
    while (n_acc < 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (r16) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        @(posedge clk);
        #1;
        if (n_acc < 3) p16_data = pixs[n_acc][15:0];
        else p16_valid = 1'b0;
      end
    end
    check("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      check("b2b_gap1", acc_t[1] - acc_t[0], 129);
      check("b2b_gap2", acc_t[2] - acc_t[1], 129);
    end
    guard = 0;
    while (b16 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_rises", rises16 - rises0, 96);
    check("b2b_words", q16.size(), 3);
    for (int i = 0; i < 3; i++)
      if (q16.size() != 0) check("b2b_word", q16.pop_front(), expand(pixs[i], 16));

    // Reset in the middle of a word.
    pix = $urandom & 32'hFFFF;
    @(negedge clk);
    p16_data = pix[15:0];
    p16_valid = 1'b1;
    @(posedge clk);
    #1;
    p16_valid = 1'b0;
    guard = 0;
    while (cnt16 < 10 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reach_bit10", 32'(cnt16 == 10), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_spi_clk", c16, 0);
    check("midrst_mosi", m16, 0);
    check("midrst_spi_reset", s16r, 1);
    check("midrst_ready", r16, 0);
    check("midrst_busy", b16, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("midrst_no_word", q16.size(), 0);
    pix = $urandom & 32'hFFFF;
    send(0, pix, $urandom, "postrst");
    check("postrst_words", q16.size(), 1);
    if (q16.size() != 0) check("postrst_word", q16.pop_front(), expand(pix, 16));

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
